light_dance_sequencer: RTL
==========================

# light_dance_sequencer

Programmable pattern sequencer that sits directly upstream of the light-dance shift/rotate stage. It drives that stage's `load`, `pdata` and `din` inputs. It holds a small writable table of 8-bit light patterns, each with a dwell time and a serial-fill bit. On `start` it plays the table in order, issuing one `load` strobe per entry, and optionally loops. The light-dance stage shares the same `clk`/`arst`.

## Interface
- `DEPTH`, 8: number of table entries (power of two, 2..16); `AW = $clog2(DEPTH)`.
- `DWELL_W`, 8: width of the per-entry dwell count.

Ports:
- `clk`  in  1  single system clock; all state on rising edge.
- `arst`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  table write strobe.
- `wr_addr`  in  AW  entry index to write.
- `wr_pattern`  in  8  pattern for the entry.
- `wr_dwell`  in  DWELL_W  dwell count for the entry.
- `wr_din`  in  1  serial-fill bit for the entry.
- `len`  in  AW+1  number of entries to play; sampled at start.
- `loop`  in  1  replay from entry 0 after the last entry; sampled continuously.
- `start`  in  1  begin playback (level sampled each cycle).
- `stop`  in  1  abort playback.
- `load`  out  1  1-cycle strobe to downstream `load`.
- `pdata`  out  8  pattern to downstream `pdata`; held between loads.
- `din`  out  1  serial bit to downstream `din`; held between loads.
- `busy`  out  1  high while playing.
- `done`  out  1  1-cycle pulse on normal completion.
- `idx`  out  AW  index of the entry currently active.

## Operation
- Table: DEPTH entries of {pattern[7:0], dwell[DWELL_W-1:0], din}.
  - Write occurs at the rising edge when `wr_en`=1, in any state.
  - A write to the active entry takes effect the next time that entry is loaded.
  - `arst` clears all entries to 0.
- Length handling:
  - At start, the effective length L = min(`len`, DEPTH), latched.
  - `len`=0 leaves start ignored.
- FSM states and transitions:
  - IDLE: `busy`=0. If `start`=1 and `stop`=0 and `len`≠0, go to LOAD with idx=0.
  - LOAD (one cycle):
    - `load`=1; `pdata`, `din` show entry[idx].
    - Dwell counter is loaded with entry[idx].dwell.
    - If dwell=0, skip RUN and go to ADVANCE.
  - RUN:
    - `load`=0.
    - Counter decrements each cycle; on the cycle it reaches 1, go to ADVANCE.
    - Gives exactly dwell cycles in RUN.
  - ADVANCE (combinational decision, no extra cycle; the next state is taken from LOAD or the last RUN cycle):
    - If idx<L-1: idx+1, go to LOAD.
    - Else if `loop`=1: idx=0, go to LOAD.
    - Else go to IDLE with a `done` pulse.
- Per-entry period is 1+dwell cycles, with no gap between entries.
- `stop`=1 in any non-IDLE state: next state is IDLE, with `load`=0, `busy`=0 and no `done`. `pdata`/`din` hold their last values.
- `start` while busy is ignored. When `start` and `stop` are asserted in the same cycle, `stop` wins.
- All outputs are registered.

## Timing
- Reset values (async, while `arst`=0): `load`=0, `pdata`=0, `din`=0, `busy`=0, `done`=0, `idx`=0, state IDLE, table cleared.
- Release of `arst` is synchronised by the surrounding design. This block acts on the first clock edge after release.
- Start latency: `start` sampled at edge k gives `load`=1, `busy`=1 and valid `pdata`/`din` during cycle k+1.
- Entry i load cycle = k+1+Σ_{j<i}(1+dwell_j).
- `done` and `busy` falling occur in the cycle after the last RUN/LOAD cycle of entry L-1. A new `start` is accepted in that same cycle.
- Reset mid-playback: outputs go to reset values immediately (asynchronously). No `done` is generated.
- Dwell counter width is DWELL_W; maximum dwell is 2^DWELL_W-1 with no wrap.
- idx wraps only via loop; it never exceeds L-1.

## Test plan
- Reset:
  - Program the table, start, then drop `arst` mid-RUN.
  - Required: all outputs 0 at once; after release, `start` with `len`=1 loads `pdata`=0x00 (table cleared).
- Single entry:
  - entry0={0x04, dwell 3, din 1}, `len`=1, `loop`=0, `start` at edge k.
  - Required: `load`=1 with `pdata`=0x04 and `din`=1 in cycle k+1; `load`=0 in cycles k+2..k+4; `done`=1 and `busy`=0 in cycle k+5.
- Back-to-back:
  - entries {0x81,0,0}, {0x42,0,1}, {0x24,2,0}, `len`=3.
  - Required: `load` high in cycles k+1, k+2, k+3; `pdata` 0x81→0x42→0x24; `done` in cycle k+6.
- Loop and stop:
  - `len`=2, `loop`=1, dwell 1 each.
  - Required: loads every 2 cycles with idx 0,1,0,1…; `stop` gives IDLE next cycle, `done` never asserted, `pdata` held.
- Corner controls:
  - `len`=0 with `start`: no activity.
  - `start`+`stop` together: no activity.
  - `len`=12 with DEPTH=8: plays 8 entries then `done`.
  - `start` during busy: ignored.
- Live write:
  - During RUN of entry 1 in loop mode, write entry1 pattern 0xFF.
  - Required: the current `pdata` is unchanged; the next load of idx 1 shows 0xFF.

Source files
------------

// File: rtl/light_dance_sequencer_if.sv
// Pattern-sequencer bus: table write port, playback controls and the
// registered outputs that feed the light-dance shift/rotate stage.
interface light_dance_sequencer_if #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned DWELL_W = 8
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic               wr_en;
  logic [AW-1:0]      wr_addr;
  logic [7:0]         wr_pattern;
  logic [DWELL_W-1:0] wr_dwell;
  logic               wr_din;
  logic [AW:0]        len;
  logic               loop;
  logic               start;
  logic               stop;

  logic               load;
  logic [7:0]         pdata;
  logic               din;
  logic               busy;
  logic               done;
  logic [AW-1:0]      idx;

  modport master (
    output wr_en, wr_addr, wr_pattern, wr_dwell, wr_din, len, loop, start, stop,
    input  load, pdata, din, busy, done, idx
  );

  modport slave (
    input  wr_en, wr_addr, wr_pattern, wr_dwell, wr_din, len, loop, start, stop,
    output load, pdata, din, busy, done, idx
  );
endinterface

// File: rtl/light_dance_sequencer.sv
// Plays a writable table of {pattern, dwell, din} entries into the downstream
// light-dance stage, one load strobe per entry, optionally looping.
module light_dance_sequencer #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned DWELL_W = 8
) (
  input logic                     clk,
  input logic                     arst,
  light_dance_sequencer_if.slave  bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [7:0]         pattern;
    logic [DWELL_W-1:0] dwell;
    logic               din;
  } entry_t;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  entry_t             tbl [DEPTH];
  state_t             state_q, nxt_state;
  logic [AW-1:0]      idx_q, nxt_idx, adv_idx;
  logic [AW:0]        len_q, nxt_len;
  logic [DWELL_W-1:0] cnt_q, nxt_cnt;
  logic               load_q, nxt_load;
  logic [7:0]         pdata_q, nxt_pdata;
  logic               din_q, nxt_din;
  logic               busy_q, nxt_busy;
  logic               done_q, nxt_done;
  logic               last_entry, advance;
  entry_t             sel;

  // Pattern table; writes allowed in any state, read again on each load.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      for (int unsigned i = 0; i < DEPTH; i++) tbl[i] <= '0;
    end else if (bus.wr_en) begin
      tbl[bus.wr_addr] <= {bus.wr_pattern, bus.wr_dwell, bus.wr_din};
    end
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      load_q  <= 1'b0;
      pdata_q <= '0;
      din_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= nxt_state;
      idx_q   <= nxt_idx;
      len_q   <= nxt_len;
      cnt_q   <= nxt_cnt;
      load_q  <= nxt_load;
      pdata_q <= nxt_pdata;
      din_q   <= nxt_din;
      busy_q  <= nxt_busy;
      done_q  <= nxt_done;
    end
  end

  // Advance target: next entry, or entry 0 after the last one.
  assign last_entry = ((AW+1)'(idx_q) + (AW+1)'(1)) >= len_q;
  assign adv_idx    = last_entry ? '0 : idx_q + AW'(1);

  always_comb begin
    nxt_state = state_q;
    nxt_idx   = idx_q;
    nxt_len   = len_q;
    nxt_cnt   = cnt_q;
    nxt_load  = 1'b0;
    nxt_pdata = pdata_q;
    nxt_din   = din_q;
    nxt_busy  = busy_q;
    nxt_done  = 1'b0;
    advance   = 1'b0;
    sel       = tbl[adv_idx];

    case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop && (bus.len != '0)) begin
          nxt_state = LOAD;
          nxt_idx   = '0;
          nxt_len   = (bus.len > DEPTH_L) ? DEPTH_L : bus.len;
          nxt_load  = 1'b1;
          nxt_pdata = tbl[0].pattern;
          nxt_din   = tbl[0].din;
          nxt_cnt   = tbl[0].dwell;
          nxt_busy  = 1'b1;
        end
      end
      LOAD: begin
        if (cnt_q == '0) advance = 1'b1;
        else             nxt_state = RUN;
      end
      RUN: begin
        if (cnt_q <= DWELL_W'(1)) advance = 1'b1;
        else                      nxt_cnt = cnt_q - DWELL_W'(1);
      end
      default: nxt_state = IDLE;
    endcase

    // Advance folds into the current cycle so entries play back to back.
    if (advance) begin
      if (!last_entry || bus.loop) begin
        nxt_state = LOAD;
        nxt_idx   = adv_idx;
        nxt_load  = 1'b1;
        nxt_pdata = sel.pattern;
        nxt_din   = sel.din;
        nxt_cnt   = sel.dwell;
      end else begin
        nxt_state = IDLE;
        nxt_busy  = 1'b0;
        nxt_done  = 1'b1;
      end
    end

    // Abort overrides everything; pattern and index hold their last values.
    if ((state_q != IDLE) && bus.stop) begin
      nxt_state = IDLE;
      nxt_idx   = idx_q;
      nxt_cnt   = cnt_q;
      nxt_load  = 1'b0;
      nxt_pdata = pdata_q;
      nxt_din   = din_q;
      nxt_busy  = 1'b0;
      nxt_done  = 1'b0;
    end
  end

  assign bus.load  = load_q;
  assign bus.pdata = pdata_q;
  assign bus.din   = din_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.idx   = idx_q;
endmodule
